// File: rtl/tcdm_arb_pkg.sv
// Shared types and constants for the TCDM bank arbiter.
package tcdm_arb_pkg;

   // Default requester count; the arbiter specialises idx/meta widths to its own NumIn.
   localparam int unsigned NumInDefault = 4;

   // Deepest bank read latency the response pipe is expected to cover.
   localparam int unsigned MaxRespLat = 4;

   typedef logic [$clog2(NumInDefault)-1:0] idx_t;

   // One in-flight response slot: whether it will raise vld and for which requester.
   typedef struct packed {
      logic valid;
      idx_t idx;
   } resp_meta_t;

endpackage : tcdm_arb_pkg

// File: rtl/tcdm_arb_resp_pipe.sv
// Fixed-depth shift register carrying response metadata alongside the bank read latency.
module tcdm_arb_resp_pipe
   import tcdm_arb_pkg::*;
#(
   parameter int unsigned Depth  = 1,
   parameter type         meta_t = resp_meta_t
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  meta_t meta_i,
   output meta_t meta_o
);

   meta_t r_stage [Depth];

   // Shift one stage per cycle; reset discards everything in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= meta_i;
         for (int i = 1; i < int'(Depth); i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign meta_o = r_stage[Depth-1];

endmodule : tcdm_arb_resp_pipe

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank port among NumIn requesters,
// with a fixed-latency pipe routing read responses back to their owner.
// Optional macro TCDM_ARB_WRITE_RESP_EN: stores also produce a vld_o pulse.
module tcdm_bank_arbiter
   import tcdm_arb_pkg::*;
#(
   parameter int unsigned NumIn        = NumInDefault,
   parameter int unsigned AddrMemWidth = 12,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned RespLat      = 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NumIn-1:0]                      req_i,
   input  logic [NumIn-1:0][AddrMemWidth-1:0]    add_i,
   input  logic [NumIn-1:0]                      wen_i,
   input  logic [NumIn-1:0][DataWidth-1:0]       wdata_i,
   input  logic [NumIn-1:0][DataWidth/8-1:0]     be_i,
   output logic [NumIn-1:0]                      gnt_o,
   output logic [NumIn-1:0]                      vld_o,
   output logic [NumIn-1:0][DataWidth-1:0]       rdata_o,
   output logic                                  req_o,
   input  logic                                  gnt_i,
   output logic [AddrMemWidth-1:0]               add_o,
   output logic                                  wen_o,
   output logic [DataWidth-1:0]                  wdata_o,
   output logic [DataWidth/8-1:0]                be_o,
   input  logic [DataWidth-1:0]                  rdata_i
);

   localparam int unsigned IdxWidth = $clog2(NumIn);

   typedef logic [IdxWidth-1:0] arb_idx_t;
   typedef struct packed {
      logic     valid;
      arb_idx_t idx;
   } arb_meta_t;

   if (RespLat < 1 || RespLat > MaxRespLat) begin : g_bad_lat
      $error("tcdm_bank_arbiter: RespLat out of range");
   end

   arb_idx_t    r_rr;
   arb_idx_t    w_winner;
   arb_idx_t    w_rr_nxt;
   logic        w_found;
   logic        w_req;
   logic        w_hs;
   logic [31:0] w_sum;
   arb_meta_t   w_meta_in;
   arb_meta_t   w_meta_out;

   assign w_req = |req_i;
   assign w_hs  = w_req & gnt_i;
   assign req_o = w_req;

   // Find the first requester at or after the pointer, wrapping at NumIn.
   always_comb begin
      w_winner = r_rr;
      w_found  = 1'b0;
      w_sum    = '0;
      for (int unsigned k = 0; k < NumIn; k++) begin
         w_sum = 32'(r_rr) + k;
         if (w_sum >= NumIn) begin
            w_sum = w_sum - NumIn;
         end
         if (!w_found && req_i[IdxWidth'(w_sum)]) begin
            w_found  = 1'b1;
            w_winner = IdxWidth'(w_sum);
         end
      end
   end

   // Pointer advances past the winner; explicit wrap keeps it in range for any NumIn.
   assign w_rr_nxt = (32'(w_winner) == NumIn - 1) ? '0 : w_winner + 1'b1;

   // Steer the winner onto the bank port and return the bank grant to it.
   always_comb begin
      gnt_o   = '0;
      add_o   = '0;
      wen_o   = 1'b0;
      wdata_o = '0;
      be_o    = '0;
      if (w_req) begin
         gnt_o[w_winner] = gnt_i;
         add_o           = add_i[w_winner];
         wen_o           = wen_i[w_winner];
         wdata_o         = wdata_i[w_winner];
         be_o            = be_i[w_winner];
      end
   end

   // Round-robin pointer moves only on a completed handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr <= '0;
      end else if (w_hs) begin
         r_rr <= w_rr_nxt;
      end
   end

`ifdef TCDM_ARB_WRITE_RESP_EN
   assign w_meta_in.valid = w_hs;
`else
   assign w_meta_in.valid = w_hs & ~wen_o;
`endif
   assign w_meta_in.idx = w_winner;

   tcdm_arb_resp_pipe #(
      .Depth  (RespLat),
      .meta_t (arb_meta_t)
   ) u_resp_pipe (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .meta_i (w_meta_in),
      .meta_o (w_meta_out)
   );

   // Decode the exiting pipe slot into a one-hot response valid.
   always_comb begin
      vld_o = '0;
      if (w_meta_out.valid) begin
         vld_o[w_meta_out.idx] = 1'b1;
      end
   end

   assign rdata_o = {NumIn{rdata_i}};

endmodule : tcdm_bank_arbiter

// File: tb/tb_tcdm_bank_arbiter.sv
// Bench for tcdm_bank_arbiter: RespLat=1 and RespLat=3 instances share all stimulus.
module tb_tcdm_bank_arbiter;

   localparam int N  = 4;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic                      clk;
   logic                      rst_n;
   logic [N-1:0]              req_i;
   logic [N-1:0][AW-1:0]      add_i;
   logic [N-1:0]              wen_i;
   logic [N-1:0][DW-1:0]      wdata_i;
   logic [N-1:0][BW-1:0]      be_i;
   logic                      gnt_i;
   logic [DW-1:0]             rdata_i;

   logic [N-1:0]              gnt1, gnt3, vld1, vld3;
   logic [N-1:0][DW-1:0]      rdo1, rdo3;
   logic                      req1, req3, wen1, wen3;
   logic [AW-1:0]             add1, add3;
   logic [DW-1:0]             wd1, wd3;
   logic [BW-1:0]             be1, be3;

   int n_checks = 0;
   int n_fail   = 0;

   tcdm_bank_arbiter #(.NumIn(N), .AddrMemWidth(AW), .DataWidth(DW), .RespLat(1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
      .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt1), .vld_o(vld1), .rdata_o(rdo1),
      .req_o(req1), .gnt_i(gnt_i), .add_o(add1), .wen_o(wen1), .wdata_o(wd1),
      .be_o(be1), .rdata_i(rdata_i));

   tcdm_bank_arbiter #(.NumIn(N), .AddrMemWidth(AW), .DataWidth(DW), .RespLat(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
      .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt3), .vld_o(vld3), .rdata_o(rdo3),
      .req_o(req3), .gnt_i(gnt_i), .add_o(add3), .wen_o(wen3), .wdata_o(wd3),
      .be_o(be3), .rdata_i(rdata_i));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Arbitration state is a plain integer pointer; responses are scheduled by cycle number.
   int           m_rr = 0;
   int           cyc  = 0;
   logic [N-1:0] exp_vld1 [0:1023];
   logic [N-1:0] exp_vld3 [0:1023];

   function automatic int pick(input logic [N-1:0] r, input int rr);
      for (int k = 0; k < N; k++) begin
         if (r[(rr + k) % N]) return (rr + k) % N;
      end
      return 0;
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) begin
         exp_vld1[i] = '0;
         exp_vld3[i] = '0;
      end
   end

   // Compare every cycle at the falling edge, then advance the model.
   always @(negedge clk) begin
      int           w;
      logic         any;
      logic         resp;
      logic [N-1:0] eg;
      if (!rst_n) begin
         m_rr = 0;
         for (int d = 0; d <= 3; d++) begin
            exp_vld1[cyc + d] = '0;
            exp_vld3[cyc + d] = '0;
         end
      end
      any = |req_i;
      w   = pick(req_i, m_rr);
      eg  = (any && gnt_i) ? N'(1 << w) : '0;
      chk("req_o",   64'(req1), 64'(any));
      chk("gnt_o",   64'(gnt1), 64'(eg));
      chk("add_o",   64'(add1), any ? 64'(add_i[w])   : 64'd0);
      chk("wen_o",   64'(wen1), any ? 64'(wen_i[w])   : 64'd0);
      chk("wdata_o", 64'(wd1),  any ? 64'(wdata_i[w]) : 64'd0);
      chk("be_o",    64'(be1),  any ? 64'(be_i[w])    : 64'd0);
      chk("gnt_o_l3", 64'(gnt3), 64'(eg));
      chk("add_o_l3", 64'(add3), any ? 64'(add_i[w]) : 64'd0);
      chk("vld_o_l1", 64'(vld1), 64'(exp_vld1[cyc]));
      chk("vld_o_l3", 64'(vld3), 64'(exp_vld3[cyc]));
      for (int k = 0; k < N; k++) begin
         chk("rdata_lane_l1", 64'(rdo1[k]), 64'(rdata_i));
         chk("rdata_lane_l3", 64'(rdo3[k]), 64'(rdata_i));
      end
      if (rst_n && any && gnt_i) begin
`ifdef TCDM_ARB_WRITE_RESP_EN
         resp = 1'b1;
`else
         resp = !wen_i[w];
`endif
         if (resp) begin
            exp_vld1[cyc + 1] = exp_vld1[cyc + 1] | N'(1 << w);
            exp_vld3[cyc + 3] = exp_vld3[cyc + 3] | N'(1 << w);
         end
         m_rr = (w + 1) % N;
      end
      cyc++;
   end

   // ---------------- directed stimulus with literal expectations ----------------
   int exp_order [8] = '{3, 0, 1, 2, 3, 0, 1, 2};

   initial begin
      int           gi;
      logic [N-1:0] store_vld;
      rst_n   = 1'b1;
      req_i   = '0;
      add_i   = '0;
      wen_i   = '0;
      wdata_i = '0;
      be_i    = '0;
      gnt_i   = 1'b0;
      rdata_i = '0;
      #1 rst_n = 1'b0;

      // Reset with no requests
      repeat (5) begin
         @(negedge clk);
         chk("rst_req_o", 64'(req1), 64'd0);
         chk("rst_gnt_o", 64'(gnt1), 64'd0);
         chk("rst_vld_o", 64'(vld1), 64'd0);
         chk("rst_add_o", 64'(add1), 64'd0);
      end

      // Single load from requester 2
      @(posedge clk); #1;
      rst_n    = 1'b1;
      req_i    = 4'b0100;
      add_i[2] = 12'h010;
      gnt_i    = 1'b1;
      @(negedge clk);
      chk("ld2_gnt", 64'(gnt1), 64'b0100);
      chk("ld2_add", 64'(add1), 64'h010);
      @(posedge clk); #1;
      req_i   = '0;
      gnt_i   = 1'b0;
      rdata_i = 32'hDEADBEEF;
      @(negedge clk);
      chk("ld2_vld",   64'(vld1),    64'b0100);
      chk("ld2_rdata", 64'(rdo1[2]), 64'hDEADBEEF);

      // All four requesting loads: rotation starts after requester 2
      for (int k = 0; k < N; k++) begin
         add_i[k]   = AW'(12'h100 + k);
         wdata_i[k] = DW'(32'h5A00_0000 + k);
         be_i[k]    = BW'(k + 1);
      end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         req_i   = 4'b1111;
         gnt_i   = 1'b1;
         rdata_i = 32'hA000_0000 + 32'(i);
         @(negedge clk);
         gi = -1;
         for (int k = 0; k < N; k++) if (gnt1[k]) gi = k;
         chk("rr_order", 64'(gi), 64'(exp_order[i]));
         if (i > 0) chk("rr_vld", 64'(vld1), 64'(1 << exp_order[i-1]));
      end
      @(posedge clk); #1;
      req_i = '0;
      gnt_i = 1'b0;
      @(negedge clk);
      chk("rr_vld_last", 64'(vld1), 64'(1 << exp_order[7]));

      // Bank stall: requester 1 waits three cycles
      @(posedge clk); #1;
      req_i = 4'b0010;
      gnt_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_gnt", 64'(gnt1), 64'd0);
         chk("stall_req", 64'(req1), 64'd1);
         chk("stall_vld", 64'(vld1), 64'd0);
         if (i < 2) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      gnt_i = 1'b1;
      @(negedge clk);
      chk("stall_release_gnt", 64'(gnt1), 64'b0010);
      // Pointer must now sit at 2
      @(posedge clk); #1;
      req_i = 4'b1111;
      @(negedge clk);
      chk("ptr_after_stall", 64'(gnt1), 64'b0100);
      chk("stall_ld_vld",    64'(vld1), 64'b0010);

      // Store from requester 3
      @(posedge clk); #1;
      req_i      = 4'b1000;
      wen_i[3]   = 1'b1;
      be_i[3]    = 4'hF;
      wdata_i[3] = 32'h1234_5678;
      add_i[3]   = 12'h3FF;
      @(negedge clk);
      chk("st_gnt",   64'(gnt1), 64'b1000);
      chk("st_wen",   64'(wen1), 64'd1);
      chk("st_wdata", 64'(wd1),  64'h1234_5678);
      chk("st_be",    64'(be1),  64'hF);
      chk("st_add",   64'(add1), 64'h3FF);
      @(posedge clk); #1;
      req_i    = '0;
      wen_i[3] = 1'b0;
      gnt_i    = 1'b0;
`ifdef TCDM_ARB_WRITE_RESP_EN
      store_vld = 4'b1000;
`else
      store_vld = 4'b0000;
`endif
      @(negedge clk);
      chk("st_vld", 64'(vld1), 64'(store_vld));

      // Pointer wrapped 3 -> 0: requester 1 wins over 2 and 3
      @(posedge clk); #1;
      req_i = 4'b1110;
      gnt_i = 1'b1;
      @(negedge clk);
      chk("wrap_gnt", 64'(gnt1), 64'b0010);

      // Reset one cycle after a load on the RespLat=3 path
      @(posedge clk); #1;
      req_i = '0;
      gnt_i = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_vld3", 64'(vld3), 64'd0);
      chk("mid_rst_vld1", 64'(vld1), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_vld3", 64'(vld3), 64'd0);
      end
      @(posedge clk); #1;
      req_i = 4'b1111;
      gnt_i = 1'b1;
      @(negedge clk);
      chk("post_rst_ptr", 64'(gnt1), 64'b0001);
      @(posedge clk); #1;
      req_i = '0;
      gnt_i = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_tcdm_bank_arbiter
